mem_port_arbiter: RTL

- Shares the single-port Main_Mem between two requesters: requester 0 is the control unit's fetch/data path, requester 1 is an I/O/DMA-style agent.
- Grants one transfer at a time, using round-robin priority between the two requesters.
- Drives the memory address, write-enable and write-data from registered copies of the winner's request.
- Returns read data with a valid strobe and the requester ID.

---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_port_arbiter_rr_arb2.sv | 12 +
 rtl/mem_port_arbiter.sv | 74 +++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state encoding and requester IDs shared by the Main_Mem port arbiter.
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;
   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_IO  = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; on contention the requester other than last wins.
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win,
   output logic       valid
);
   assign valid = |req;
   assign win   = (req == 2'b11) ? ((last == REQ_IO) ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares single-port Main_Mem between the control unit (0) and an I/O agent (1),
// one transfer at a time, with registered memory drive and tagged read-data return.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int READ_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   input  logic [1:0]    we,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [1:0]    gnt,
   output logic          rvalid,
   output logic          rid,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);
   state_t     state, state_nx;
   logic [1:0] win;
   logic       win_v, win_id, last, grant, done;
   logic [1:0] cnt;
   rr_arb2 u_arb (.req(req), .last(last), .win(win), .valid(win_v));
   assign win_id = win[1];
   // a write frees the port after its single ACCESS cycle, so the next winner can go back-to-back
   assign grant  = win_v && (state == ST_IDLE || (state == ST_ACCESS && mem_we));
   assign done   = state == ST_WAIT && cnt == '0;
   assign busy   = state != ST_IDLE;
   always_comb begin
      state_nx = grant ? ST_ACCESS
               : (state == ST_ACCESS) ? (mem_we ? ST_IDLE : ST_WAIT)
               : done ? ST_IDLE : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         gnt       <= '0;
         rvalid    <= 1'b0;
         rid       <= REQ_CPU;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         last      <= REQ_IO;
         cnt       <= '0;
      end else begin
         gnt    <= grant ? win : 2'b00;
         mem_we <= grant && (win_id ? we[1] : we[0]);
         rvalid <= done;
         if (grant) begin
            mem_addr  <= win_id ? addr1 : addr0;
            mem_wdata <= win_id ? wdata1 : wdata0;
            last      <= win_id;
         end
         if (state == ST_ACCESS) cnt <= LAT_M1;
         else if (state == ST_WAIT && cnt != '0) cnt <= cnt - 2'd1;
         if (done) begin
            rdata <= mem_rdata;
            rid   <= last;
         end
      end
endmodule
